// File: rtl/pes_traffic_multi_pkg.sv
// Shared types, lamp encodings and the round-robin selector for the
// multi-approach traffic controller.
package pes_traffic_pkg;

  localparam int MAX_APP = 8;

  typedef enum logic [1:0] {
    GREEN   = 2'd0,
    YELLOW  = 2'd1,
    ALL_RED = 2'd2
  } state_t;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  // First set bit strictly after cur, wrapping modulo n; cur itself is never
  // picked. Falls back to home (0) when nothing else is pending.
  function automatic logic [2:0] rr_next(input logic [MAX_APP-1:0] pend,
                                         input logic [2:0]         cur,
                                         input int unsigned        n);
    logic [2:0]  res;
    int unsigned idx;
    res = '0;
    // Walk from the farthest candidate back so the nearest one wins.
    for (int unsigned k = MAX_APP - 1; k >= 1; k--) begin
      if (k < n) begin
        idx = (32'(cur) + k) % n;
        if (pend[idx[2:0]]) res = idx[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pes_traffic_multi_if.sv
// Sensor-to-controller-to-lamp bundle. There is no valid/ready handshake:
// req is a level or pulse sampled on every clk, all outputs are plain status.
interface pes_traffic_multi_if #(
  parameter int NUM_APP = 4
);
  localparam int PW = (NUM_APP > 1) ? $clog2(NUM_APP) : 1;

  logic [NUM_APP-1:0]   req;
  logic [3*NUM_APP-1:0] lights;
  logic [PW-1:0]        phase;
  logic [1:0]           state;
  logic [NUM_APP-1:0]   pending;

  modport master (output req, input lights, input phase, input state, input pending);
  modport slave  (input req, output lights, output phase, output state, output pending);
endinterface

// File: rtl/pes_traffic_multi_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, realigned to zero
// whenever the controller changes state.
module pes_tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || tick) cnt <= '0;
    else                        cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/pes_traffic_multi.sv
// N-approach intersection controller: latched requests, round-robin service,
// home approach 0 rests green; each phase runs green, yellow, all-red.
module pes_traffic_multi
  import pes_traffic_pkg::*;
#(
  parameter int NUM_APP   = 4,
  parameter int TICK_DIV  = 4,
  parameter int MIN_GREEN = 10,
  parameter int GREEN_T   = 10,
  parameter int YEL_T     = 3,
  parameter int AR_T      = 1,
  parameter int TW        = 8
) (
  input  logic clk,
  input  logic rst,
  pes_traffic_multi_if.slave bus
);
  localparam int PW = (NUM_APP > 1) ? $clog2(NUM_APP) : 1;

  localparam logic [TW:0] MIN_G = (TW+1)'(MIN_GREEN);
  localparam logic [TW:0] GRN   = (TW+1)'(GREEN_T);
  localparam logic [TW:0] YEL   = (TW+1)'(YEL_T);
  localparam logic [TW:0] AR    = (TW+1)'(AR_T);

  state_t             st, st_nx;
  logic [PW-1:0]      ph, ph_nx, ph_rr;
  logic [TW-1:0]      timer;
  logic [TW:0]        timer_inc;
  logic [NUM_APP-1:0] pend, pend_nx;
  logic [MAX_APP-1:0] pend_ext;
  logic               tick, change, enter_green;

  pes_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (change),
    .tick    (tick)
  );

  assign timer_inc   = {1'b0, timer} + 1'b1;
  assign pend_ext    = MAX_APP'(pend);
  assign ph_rr       = PW'(rr_next(pend_ext, 3'(ph), NUM_APP));
  assign change      = (st_nx != st);
  assign enter_green = change && (st_nx == GREEN);

  always_ff @(posedge clk) begin
    if (rst) begin
      st    <= GREEN;
      ph    <= '0;
      timer <= '0;
      pend  <= '0;
    end else begin
      st   <= st_nx;
      ph   <= ph_nx;
      pend <= pend_nx;
      if (change)                  timer <= '0;
      else if (tick && timer != '1) timer <= timer + 1'b1;
    end
  end

  // Every transition is gated by tick, so a state lasts whole ticks only.
  always_comb begin
    st_nx = st;
    ph_nx = ph;
    if (tick) begin
      case (st)
        GREEN: begin
          if (ph == '0) begin
            if (timer_inc >= MIN_G && |pend) st_nx = YELLOW;
          end else if (timer_inc == GRN) begin
            st_nx = YELLOW;
          end
        end
        YELLOW: begin
          if (timer_inc == YEL) st_nx = ALL_RED;
        end
        ALL_RED: begin
          if (timer_inc == AR) begin
            st_nx = GREEN;
            ph_nx = ph_rr;
          end
        end
        default: st_nx = GREEN;
      endcase
    end
  end

  // Home never latches; the current green approach ignores its own sensor,
  // and the green-entry clear overrides a same-cycle request.
  always_comb begin
    pend_nx = pend;
    for (int i = 1; i < NUM_APP; i++) begin
      if (bus.req[i] && !(st == GREEN && ph == PW'(i))) pend_nx[i] = 1'b1;
      if (enter_green && ph_nx == PW'(i))               pend_nx[i] = 1'b0;
    end
  end

  always_comb begin
    bus.lights = '0;
    for (int i = 0; i < NUM_APP; i++) begin
      bus.lights[3*i +: 3] = LIGHT_RED;
      if (ph == PW'(i)) begin
        if (st == GREEN)       bus.lights[3*i +: 3] = LIGHT_GRN;
        else if (st == YELLOW) bus.lights[3*i +: 3] = LIGHT_YEL;
      end
    end
  end

  assign bus.phase   = ph;
  assign bus.state   = st;
  assign bus.pending = pend;

endmodule
